// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - parametrised saturating BCD score counter with optional high-score tracking
// Define SCORE_HISCORE_EN to build the high-score register, comparator and new_record flag.
module score_keeper #(
  parameter int DIGITS = 3,
  parameter int AMT_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                incr,
  input  logic [AMT_W-1:0]    amount,
  input  logic                clear,
  input  logic                game_over,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [4*DIGITS-1:0] hiscore_bcd,
  output logic                saturated,
  output logic                new_record
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic          incr_q;
  logic          incr_armed;
  logic          inc_ev;
  logic [31:0]   amount_ext;
  logic [3:0]    amt;
  logic [3:0]    carry;
  logic [4:0]    digit_sum;
  logic [W-1:0]  sum_bcd;
  logic          carry_out;

  // incr_armed blocks an event from an incr that was already high when reset released
  assign inc_ev     = incr & ~incr_q & incr_armed;
  assign amount_ext = 32'(amount);
  assign amt        = (amount_ext > 32'd9) ? 4'd9 : amount_ext[3:0];

  always_comb begin
    sum_bcd   = '0;
    digit_sum = '0;
    carry     = amt;
    for (int i = 0; i < DIGITS; i++) begin
      digit_sum = {1'b0, score_bcd[4*i +: 4]} + {1'b0, carry};
      if (digit_sum > 5'd9) begin
        sum_bcd[4*i +: 4] = digit_sum[3:0] - 4'd10;
        carry             = 4'd1;
      end else begin
        sum_bcd[4*i +: 4] = digit_sum[3:0];
        carry             = 4'd0;
      end
    end
    carry_out = carry[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_bcd  <= '0;
      saturated  <= 1'b0;
      incr_q     <= 1'b0;
      incr_armed <= 1'b0;
    end else begin
      incr_q     <= incr;
      incr_armed <= incr_armed | ~incr;
      if (clear) begin
        score_bcd <= '0;
        saturated <= 1'b0;
      end else if (inc_ev) begin
        if (carry_out) begin
          score_bcd <= ALL_NINES;
          saturated <= 1'b1;
        end else begin
          score_bcd <= sum_bcd;
        end
      end
    end
  end

`ifdef SCORE_HISCORE_EN
  logic go_q;
  logic go_ev;

  assign go_ev = game_over & ~go_q;

  // Commit compares the registered (pre-increment, pre-clear) score
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go_q        <= 1'b0;
      hiscore_bcd <= '0;
      new_record  <= 1'b0;
    end else begin
      go_q <= game_over;
      if (clear)
        new_record <= 1'b0;
      if (go_ev) begin
        if (score_bcd > hiscore_bcd) begin
          hiscore_bcd <= score_bcd;
          new_record  <= 1'b1;
        end else begin
          new_record  <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_game_over;

  assign unused_game_over = game_over;
  assign hiscore_bcd      = '0;
  assign new_record       = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed self-checking bench for score_keeper (DIGITS=3, AMT_W=4)
module tb_score_keeper;

`ifdef SCORE_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        incr;
  logic [3:0]  amount;
  logic        clear;
  logic        game_over;
  logic [11:0] score_bcd;
  logic [11:0] hiscore_bcd;
  logic        saturated;
  logic        new_record;

  int checks;
  int errors;

  score_keeper #(.DIGITS(3), .AMT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .incr        (incr),
    .amount      (amount),
    .clear       (clear),
    .game_over   (game_over),
    .score_bcd   (score_bcd),
    .hiscore_bcd (hiscore_bcd),
    .saturated   (saturated),
    .new_record  (new_record)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    incr      = 1'b0;
    amount    = 4'd0;
    clear     = 1'b0;
    game_over = 1'b0;
    reset     = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_incr(input int n, input logic [3:0] a);
    amount = a;
    for (int i = 0; i < n; i++) begin
      incr = 1'b1;
      tick();
      incr = 1'b0;
      tick();
    end
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic pulse_go;
    game_over = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (score_bcd !== 12'h000) begin errors++; $display("FAIL reset_score got=%h exp=%h", score_bcd, 12'h000); end
    checks++;
    if (hiscore_bcd !== 12'h000) begin errors++; $display("FAIL reset_hiscore got=%h exp=%h", hiscore_bcd, 12'h000); end
    checks++;
    if (saturated !== 1'b0) begin errors++; $display("FAIL reset_saturated got=%b exp=0", saturated); end
    checks++;
    if (new_record !== 1'b0) begin errors++; $display("FAIL reset_new_record got=%b exp=0", new_record); end
  endtask

  task automatic test_basic_count;
    do_reset();
    // first event is visible right after the sampling edge
    amount = 4'd1;
    incr   = 1'b1;
    tick();
    checks++;
    if (score_bcd !== 12'h001) begin errors++; $display("FAIL latency_score got=%h exp=%h", score_bcd, 12'h001); end
    incr = 1'b0;
    tick();
    pulse_incr(122, 4'd1);
    checks++;
    if (score_bcd !== 12'h123) begin errors++; $display("FAIL basic_count got=%h exp=%h", score_bcd, 12'h123); end
    checks++;
    if (saturated !== 1'b0) begin errors++; $display("FAIL basic_count_sat got=%b exp=0", saturated); end
  endtask

  task automatic test_hold_clamp;
    do_clear();
    tick();
    checks++;
    if (score_bcd !== 12'h000) begin errors++; $display("FAIL clear_score got=%h exp=%h", score_bcd, 12'h000); end
    amount = 4'd15;
    incr   = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    incr = 1'b0;
    tick();
    checks++;
    if (score_bcd !== 12'h009) begin errors++; $display("FAIL hold_clamp got=%h exp=%h", score_bcd, 12'h009); end
  endtask

  task automatic test_saturation;
    // 995 + 4 lands on 999 without a carry: not saturated
    do_clear();
    tick();
    pulse_incr(110, 4'd9);
    pulse_incr(1, 4'd5);
    checks++;
    if (score_bcd !== 12'h995) begin errors++; $display("FAIL sat_setup got=%h exp=%h", score_bcd, 12'h995); end
    pulse_incr(1, 4'd4);
    checks++;
    if (score_bcd !== 12'h999 || saturated !== 1'b0) begin
      errors++; $display("FAIL exact_999 got=%h/%b exp=999/0", score_bcd, saturated);
    end
    pulse_incr(1, 4'd0);
    checks++;
    if (score_bcd !== 12'h999 || saturated !== 1'b0) begin
      errors++; $display("FAIL zero_amount got=%h/%b exp=999/0", score_bcd, saturated);
    end
    pulse_incr(1, 4'd1);
    checks++;
    if (score_bcd !== 12'h999 || saturated !== 1'b1) begin
      errors++; $display("FAIL sat_by_one got=%h/%b exp=999/1", score_bcd, saturated);
    end
    do_clear();
    tick();
    pulse_incr(110, 4'd9);
    pulse_incr(1, 4'd5);
    pulse_incr(1, 4'd7);
    checks++;
    if (score_bcd !== 12'h999 || saturated !== 1'b1) begin
      errors++; $display("FAIL carry_sat got=%h/%b exp=999/1", score_bcd, saturated);
    end
    pulse_incr(1, 4'd1);
    checks++;
    if (score_bcd !== 12'h999 || saturated !== 1'b1) begin
      errors++; $display("FAIL sat_hold got=%h/%b exp=999/1", score_bcd, saturated);
    end
    do_clear();
    tick();
    checks++;
    if (score_bcd !== 12'h000 || saturated !== 1'b0) begin
      errors++; $display("FAIL sat_clear got=%h/%b exp=000/0", score_bcd, saturated);
    end
  endtask

  task automatic test_record;
    do_reset();
    pulse_incr(4, 4'd9);
    pulse_incr(1, 4'd6);
    pulse_go();
    checks++;
    if (hiscore_bcd !== (HI_EN ? 12'h042 : 12'h000)) begin
      errors++; $display("FAIL record_hiscore got=%h exp=%h", hiscore_bcd, HI_EN ? 12'h042 : 12'h000);
    end
    checks++;
    if (new_record !== HI_EN) begin errors++; $display("FAIL record_flag got=%b exp=%b", new_record, HI_EN); end
    game_over = 1'b0;
    tick();
    do_clear();
    tick();
    checks++;
    if (new_record !== 1'b0) begin errors++; $display("FAIL clear_drops_flag got=%b exp=0", new_record); end
    pulse_incr(3, 4'd9);
    pulse_incr(1, 4'd3);
    checks++;
    if (score_bcd !== 12'h030) begin errors++; $display("FAIL record_lower_score got=%h exp=%h", score_bcd, 12'h030); end
    pulse_go();
    checks++;
    if (hiscore_bcd !== (HI_EN ? 12'h042 : 12'h000) || new_record !== 1'b0) begin
      errors++; $display("FAIL no_record got=%h/%b exp=%h/0", hiscore_bcd, new_record, HI_EN ? 12'h042 : 12'h000);
    end
    game_over = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous;
    do_reset();
    pulse_incr(5, 4'd9);
    pulse_incr(1, 4'd5);
    amount    = 4'd5;
    incr      = 1'b1;
    game_over = 1'b1;
    tick();
    checks++;
    if (score_bcd !== 12'h055) begin errors++; $display("FAIL simul_score got=%h exp=%h", score_bcd, 12'h055); end
    checks++;
    if (hiscore_bcd !== (HI_EN ? 12'h050 : 12'h000) || new_record !== HI_EN) begin
      errors++; $display("FAIL simul_commit got=%h/%b exp=%h/%b", hiscore_bcd, new_record, HI_EN ? 12'h050 : 12'h000, HI_EN);
    end
    incr      = 1'b0;
    game_over = 1'b0;
    tick();
    clear = 1'b1;
    incr  = 1'b1;
    tick();
    clear = 1'b0;
    incr  = 1'b0;
    checks++;
    if (score_bcd !== 12'h000) begin errors++; $display("FAIL clear_beats_incr got=%h exp=%h", score_bcd, 12'h000); end
    tick();
    // clear with a commit: commit sees the pre-clear 070 and still records it
    pulse_incr(7, 4'd9);
    pulse_incr(1, 4'd7);
    clear     = 1'b1;
    game_over = 1'b1;
    tick();
    clear     = 1'b0;
    game_over = 1'b0;
    checks++;
    if (score_bcd !== 12'h000 || hiscore_bcd !== (HI_EN ? 12'h070 : 12'h000) || new_record !== HI_EN) begin
      errors++; $display("FAIL clear_with_commit got=%h/%h/%b exp=000/%h/%b", score_bcd, hiscore_bcd, new_record, HI_EN ? 12'h070 : 12'h000, HI_EN);
    end
    tick();
  endtask

  task automatic test_async_reset;
    do_reset();
    pulse_incr(8, 4'd9);
    pulse_incr(1, 4'd5);
    pulse_go();
    game_over = 1'b0;
    checks++;
    if (score_bcd !== 12'h077) begin errors++; $display("FAIL async_setup got=%h exp=%h", score_bcd, 12'h077); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (score_bcd !== 12'h000 || hiscore_bcd !== 12'h000 || saturated !== 1'b0 || new_record !== 1'b0) begin
      errors++; $display("FAIL async_reset got=%h/%h/%b/%b exp=000/000/0/0", score_bcd, hiscore_bcd, saturated, new_record);
    end
    tick();
    amount = 4'd1;
    incr   = 1'b1;
    reset  = 1'b0;
    tick();
    tick();
    checks++;
    if (score_bcd !== 12'h000) begin errors++; $display("FAIL held_incr_after_reset got=%h exp=%h", score_bcd, 12'h000); end
    incr = 1'b0;
    tick();
    incr = 1'b1;
    tick();
    incr = 1'b0;
    checks++;
    if (score_bcd !== 12'h001) begin errors++; $display("FAIL rearm_after_low got=%h exp=%h", score_bcd, 12'h001); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    incr      = 1'b0;
    amount    = 4'd0;
    clear     = 1'b0;
    game_over = 1'b0;
    test_reset();
    test_basic_count();
    test_hold_clamp();
    test_saturation();
    test_record();
    test_simultaneous();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
